// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared control-path definitions for the branch redirect controller.
package core_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // A redirect target is legal only when it is word aligned.
  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX resolution inputs, fetch redirect handshake and pipeline kill signals.
interface branch_redirect_ctrl_if;
  import core_ctrl_pkg::*;

  logic            ex_valid_i;
  logic            ex_is_branch_i;
  logic            ex_is_jump_i;
  logic            ex_taken_i;
  logic [XLEN-1:0] ex_target_i;
  logic            ex_ready_o;
  logic            redir_valid_o;
  logic [XLEN-1:0] redir_pc_o;
  logic            redir_ready_i;
  logic            flush_o;
  logic            misalign_o;

  // Pipeline/fetch side driving EX results and accepting redirects.
  modport master (
    output ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i, ex_target_i, redir_ready_i,
    input  ex_ready_o, redir_valid_o, redir_pc_o, flush_o, misalign_o
  );

  // Redirect controller side.
  modport slave (
    input  ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i, ex_target_i, redir_ready_i,
    output ex_ready_o, redir_valid_o, redir_pc_o, flush_o, misalign_o
  );

endinterface

// File: rtl/branch_redirect_ctrl_perf_counter.sv
// Free-running event counter, wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count value.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences fetch redirects and pipeline flushes after branch/jump resolution in EX.
module branch_redirect_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  branch_redirect_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]       branch_cnt_o,
  output logic [CNT_W-1:0]       taken_cnt_o
);

  localparam int unsigned    FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ready_c;
  logic resolve_c;
  logic redirect_c;
  logic bad_target_c;
  logic take_c;
  logic branch_inc_c;

  // EX handshake decode; EX is only accepted while idle and enabled.
  always_comb begin
    ready_c      = start_i & (state_q == IDLE);
    resolve_c    = bus.ex_valid_i & ready_c;
    redirect_c   = resolve_c & (bus.ex_is_jump_i | (bus.ex_is_branch_i & bus.ex_taken_i));
    bad_target_c = is_misaligned(bus.ex_target_i[1:0]);
    take_c       = redirect_c & ~bad_target_c;
    branch_inc_c = resolve_c & bus.ex_is_branch_i;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping start_i always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!start_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (take_c)            state_d = REDIR;
        REDIR:   if (bus.redir_ready_i) state_d = FLUSH;
        FLUSH:   if (flush_cnt_q == '0) state_d = IDLE;
        default:                        state_d = IDLE;
      endcase
    end
  end

  // Output and flush-window next values, registered below.
  always_comb begin
    redir_valid_d = (state_d == REDIR);
    flush_d       = (state_d == FLUSH);
    misalign_d    = redirect_c & bad_target_c;
    redir_pc_d    = redir_pc_q;
    flush_cnt_d   = flush_cnt_q;
    if (take_c) begin
      redir_pc_d = bus.ex_target_i;
    end
    if ((state_q == REDIR) && (state_d == FLUSH)) begin
      flush_cnt_d = FC_LOAD;
    end else if ((state_q == FLUSH) && (flush_cnt_q != '0)) begin
      flush_cnt_d = flush_cnt_q - FC_W'(1);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      flush_cnt_q   <= '0;
    end else begin
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.ex_ready_o    = ready_c;
  assign bus.redir_valid_o = redir_valid_q;
  assign bus.redir_pc_o    = redir_pc_q;
  assign bus.flush_o       = flush_q;
  assign bus.misalign_o    = misalign_q;

  perf_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (branch_inc_c),
    .cnt_o (branch_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (take_c),
    .cnt_o (taken_cnt_o)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: driver pushes expectations, monitor pops and compares.
module tb_branch_redirect_ctrl;
  import core_ctrl_pkg::*;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_W        = 4;
  localparam int          CNT_MASK     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] taken_cnt_o;

  branch_redirect_ctrl_if bus ();

  branch_redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .bus          (bus),
    .branch_cnt_o (branch_cnt_o),
    .taken_cnt_o  (taken_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [XLEN-1:0] pc; int cyc;} redir_exp_t;
  typedef struct {int start; int len;} flush_exp_t;
  typedef struct {bit ready; bit valid; bit flush; bit mis; int branch; int taken;} stat_exp_t;

  redir_exp_t exp_redir[$];
  flush_exp_t exp_flush[$];
  int         exp_mis[$];
  stat_exp_t  exp_stat[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: "waiting for fetch" flag, first cycle the EX port is free again, counters.
  bit m_wait;
  int m_free_at;
  int m_branch;
  int m_taken;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_free_at = 0; m_branch = 0; m_taken = 0;
    exp_redir.delete(); exp_flush.delete(); exp_mis.delete(); exp_stat.delete();
  endtask

  // Drive one cycle of stimulus (called at a negedge), predict its effect, wait to next negedge.
  task automatic step(input bit st, input bit v, input bit br, input bit jp, input bit tk,
                      input logic [XLEN-1:0] tgt, input bit rdy);
    int k;
    bit idle_now;
    bit mis_now;
    stat_exp_t e;
    redir_exp_t r;
    flush_exp_t f;
    start_i = st; bus.ex_valid_i = v; bus.ex_is_branch_i = br; bus.ex_is_jump_i = jp;
    bus.ex_taken_i = tk; bus.ex_target_i = tgt; bus.redir_ready_i = rdy;
    k = cyc;
    idle_now = !m_wait && (k >= m_free_at);
    mis_now = 1'b0;
    if (!st) begin
      if (!m_wait && (k + 1 < m_free_at) && exp_flush.size() > 0) begin
        f = exp_flush.pop_back();
        f.len = k - f.start + 1;
        exp_flush.push_back(f);
      end
      m_wait = 1'b0;
      m_free_at = 0;
    end else if (idle_now) begin
      if (v && br) m_branch = (m_branch + 1) & CNT_MASK;
      if (v && (jp || (br && tk))) begin
        if (tgt[1:0] == 2'b00) begin
          r.pc = tgt; r.cyc = k + 1;
          exp_redir.push_back(r);
          m_wait = 1'b1;
          m_taken = (m_taken + 1) & CNT_MASK;
        end else begin
          exp_mis.push_back(k + 1);
          mis_now = 1'b1;
        end
      end
    end else if (m_wait && rdy) begin
      m_wait = 1'b0;
      f.start = k + 1; f.len = FLUSH_CYCLES;
      exp_flush.push_back(f);
      m_free_at = k + 1 + FLUSH_CYCLES;
    end
    e.ready  = st && !m_wait && (k + 1 >= m_free_at);
    e.valid  = m_wait;
    e.flush  = st && (k + 1 < m_free_at);
    e.mis    = mis_now;
    e.branch = m_branch;
    e.taken  = m_taken;
    exp_stat.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, '0, 1);
  endtask

  // Let fetch accept and the flush window drain, with a bounded budget.
  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((m_wait || cyc < m_free_at) && n < maxc) begin
      step(1, 0, 0, 0, 0, '0, 1);
      n++;
    end
    chk("drain_within_budget", (!m_wait && cyc >= m_free_at), 1);
  endtask

  // Monitor: per-cycle status plus event queues for redirects, misalign pulses and flush windows.
  initial begin
    bit prev_valid;
    bit prev_flush;
    logic [XLEN-1:0] cur_pc;
    int run_start;
    stat_exp_t e;
    redir_exp_t r;
    flush_exp_t f;
    int mc;
    prev_valid = 0; prev_flush = 0; cur_pc = '0; run_start = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_valid = 0;
        prev_flush = 0;
      end else begin
        if (exp_stat.size() > 0) begin
          e = exp_stat.pop_front();
          chk("ex_ready_o", bus.ex_ready_o, e.ready);
          chk("redir_valid_o", bus.redir_valid_o, e.valid);
          chk("flush_o", bus.flush_o, e.flush);
          chk("misalign_o", bus.misalign_o, e.mis);
          chk("branch_cnt_o", branch_cnt_o, e.branch);
          chk("taken_cnt_o", taken_cnt_o, e.taken);
        end
        if (bus.redir_valid_o && !prev_valid) begin
          chk("redirect_expected", exp_redir.size() > 0, 1);
          if (exp_redir.size() > 0) begin
            r = exp_redir.pop_front();
            chk("redir_pc_o", bus.redir_pc_o, r.pc);
            chk("redir_latency_cycle", cyc, r.cyc);
            cur_pc = r.pc;
          end
        end else if (bus.redir_valid_o) begin
          chk("redir_pc_stable", bus.redir_pc_o, cur_pc);
        end
        if (bus.misalign_o) begin
          chk("misalign_expected", exp_mis.size() > 0, 1);
          if (exp_mis.size() > 0) begin
            mc = exp_mis.pop_front();
            chk("misalign_cycle", cyc, mc);
          end
        end
        if (bus.flush_o && !prev_flush) run_start = cyc;
        if (!bus.flush_o && prev_flush) begin
          chk("flush_expected", exp_flush.size() > 0, 1);
          if (exp_flush.size() > 0) begin
            f = exp_flush.pop_front();
            chk("flush_start_cycle", run_start, f.start);
            chk("flush_length", cyc - run_start, f.len);
          end
        end
        prev_valid = bus.redir_valid_o;
        prev_flush = bus.flush_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] tgt;
    rst_n = 1'b0; start_i = 1'b0;
    bus.ex_valid_i = 0; bus.ex_is_branch_i = 0; bus.ex_is_jump_i = 0;
    bus.ex_taken_i = 0; bus.ex_target_i = '0; bus.redir_ready_i = 0;
    model_reset();

    // Reset values.
    #3;
    chk("rst_redir_valid", bus.redir_valid_o, 0);
    chk("rst_redir_pc", bus.redir_pc_o, 0);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_misalign", bus.misalign_o, 0);
    chk("rst_branch_cnt", branch_cnt_o, 0);
    chk("rst_taken_cnt", taken_cnt_o, 0);
    chk("rst_ex_ready_no_start", bus.ex_ready_o, 0);
    start_i = 1'b1;
    #1;
    chk("rst_ex_ready_start", bus.ex_ready_o, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Taken branch, fetch ready immediately.
    step(1, 1, 1, 0, 1, 32'h100, 1);
    idle_cycles(5);
    // Not-taken branch.
    step(1, 1, 1, 0, 0, 32'h200, 1);
    idle_cycles(3);
    // JAL with fetch stalling.
    step(1, 1, 0, 1, 0, 32'h2000, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 1, 32'h40, 0);
    step(1, 0, 0, 0, 0, '0, 1);
    idle_cycles(4);
    // Misaligned taken target.
    step(1, 1, 1, 0, 1, 32'h102, 1);
    idle_cycles(2);
    // Branch and jump both set: redirect and branch count.
    step(1, 1, 1, 1, 0, 32'h3000, 1);
    drain(20);
    idle_cycles(1);
    // start_i dropped during the flush window.
    step(1, 1, 0, 1, 0, 32'h400, 0);
    step(1, 0, 0, 0, 0, '0, 1);
    step(0, 1, 1, 0, 1, 32'h500, 1);
    step(0, 0, 0, 0, 0, '0, 0);
    idle_cycles(3);
    // start_i dropped while waiting for fetch.
    step(1, 1, 0, 1, 0, 32'h600, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, 0, '0, 1);
    idle_cycles(3);

    // Asynchronous reset while a redirect is outstanding.
    step(1, 1, 0, 1, 0, 32'h700, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_redir_valid", bus.redir_valid_o, 0);
    chk("arst_redir_pc", bus.redir_pc_o, 0);
    chk("arst_flush", bus.flush_o, 0);
    chk("arst_branch_cnt", branch_cnt_o, 0);
    chk("arst_taken_cnt", taken_cnt_o, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);

    // Sixteen taken branches wrap the 4-bit counters.
    for (int i = 0; i < 16; i++) begin
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      step(1, 1, 1, 0, 1, tgt, 1);
      drain(20);
    end
    idle_cycles(1);
    chk("taken_cnt_wrap", taken_cnt_o, 0);
    chk("branch_cnt_wrap", branch_cnt_o, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      tgt = $urandom;
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      step(1'($urandom_range(31) != 0), 1'($urandom_range(9) < 6), 1'($urandom_range(1)),
           1'($urandom_range(3) == 0), 1'($urandom_range(1)), tgt, 1'($urandom_range(1)));
    end
    drain(50);
    idle_cycles(2);
    chk("redir_queue_empty", exp_redir.size(), 0);
    chk("flush_queue_empty", exp_flush.size(), 0);
    chk("misalign_queue_empty", exp_mis.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
